eth_rx_port_arbiter: RTL
========================

# eth_rx_port_arbiter

Frame-granular round-robin arbiter that shares the single Ethernet frame formatter among several MAC receive ports. It sits between the per-port MAC RX streams and the formatter's `src_eth_format_*` input. It grants one port for a whole frame and passes that frame through unmodified. It tags the frame with the winning port index so downstream logic can attribute the parsed header.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of MAC RX requesters, legal range 2..16.
- `PORT_ID_W`, default `$clog2(NUM_PORTS)`: width of the port index.

Ports. Clock is `clk`; reset is `rst_n`, synchronous and active-low; one clock domain.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `src_arb_val`  in  NUM_PORTS  per-port beat valid.
- `src_arb_data`  in  NUM_PORTS*`MAC_INTERFACE_W`  per-port data, port i at slice i.
- `src_arb_frame_size`  in  NUM_PORTS*`MTU_SIZE_W`  per-port frame size; valid on the first beat.
- `src_arb_data_last`  in  NUM_PORTS  per-port last beat.
- `src_arb_data_padbytes`  in  NUM_PORTS*`MAC_PADBYTES_W`  per-port padbytes; valid on the last beat.
- `arb_src_rdy`  out  NUM_PORTS  per-port ready; only the granted bit may be 1.
- `arb_dst_val`  out  1  to formatter `src_eth_format_val`.
- `arb_dst_data`  out  `MAC_INTERFACE_W`  granted data.
- `arb_dst_frame_size`  out  `MTU_SIZE_W`  granted frame size.
- `arb_dst_data_last`  out  1  granted last.
- `arb_dst_data_padbytes`  out  `MAC_PADBYTES_W`  granted padbytes.
- `dst_arb_rdy`  in  1  from formatter `eth_format_src_rdy`.
- `arb_dst_port_id`  out  PORT_ID_W  index of the granted port; stable for the whole frame.
- `arb_frames_done`  out  32  count of frames completed; wraps at 2^32.

## Operation
The arbiter has two states, `ARB` and `STREAM`. Registers are `state`, `grant_idx`, `rr_ptr` and `frames_done`.

`ARB` state:
- All `arb_src_rdy` = 0 and `arb_dst_val` = 0.
- If any `src_arb_val` bit is set, pick the first set bit searching upward from `rr_ptr` with modular wrap.
- Register the winner into `grant_idx` and move to `STREAM`.
- If no bit is set, stay in `ARB`.

`STREAM` state is a combinational pass-through of the granted port:
- `arb_dst_val` = `src_arb_val[grant_idx]`.
- `arb_dst_data`, `arb_dst_frame_size`, `arb_dst_data_last` and `arb_dst_data_padbytes` are the `grant_idx` slices.
- `arb_src_rdy[grant_idx]` = `dst_arb_rdy`; all other bits = 0.
- A beat is accepted when `arb_dst_val` & `dst_arb_rdy`.
- When an accepted beat has last = 1:
  - `rr_ptr` ← (`grant_idx`+1) mod NUM_PORTS.
  - `frames_done` increments.
  - State returns to `ARB`.

General rules:
- The grant is never preempted. If the granted port drops `val` mid-frame, the arbiter holds `STREAM` and emits no beats until the frame's last beat.
- `arb_dst_port_id` = `grant_idx` in both states. It holds its last value while in `ARB`.
- Downstream data and sideband outputs are don't-care when `arb_dst_val` = 0. Drive them to 0 in `ARB`.

## Timing
Reset (`rst_n` = 0 at a clk edge):
- State goes to `ARB`; `grant_idx`, `rr_ptr` and `frames_done` go to 0.
- All outputs read 0 on the following cycle: `arb_src_rdy`, `arb_dst_val`, data/sideband, `arb_dst_port_id`, `arb_frames_done`.
- Reset mid-frame abandons the frame. The requester must restart from beat 0; this is acceptable only with a system-wide reset.

Latency and throughput:
- Requests are sampled in `ARB`. The first beat can be presented one cycle after the arbitration cycle.
- The combinational path val→val and rdy→rdy adds 0 cycles of data latency.
- There is a one-cycle `ARB` bubble between consecutive frames, including back-to-back frames from the same single requester.
- A one-beat frame (first beat = last) occupies `ARB` plus one `STREAM` cycle.

Handshake rules:
- `arb_src_rdy[i]` must not depend on `src_arb_val[i]`.
- A beat is consumed from port i only in a cycle with `src_arb_val[i]` & `arb_src_rdy[i]`.

Simultaneous events:
- A request arriving in the same cycle as the last-beat acceptance is not arbitrated until the next `ARB` cycle.
- With all ports requesting continuously, grants rotate 0,1,2,…,N-1,0.

Wrap rules:
- `rr_ptr` wraps from NUM_PORTS-1 to 0.
- `frames_done` wraps silently.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with all ports requesting → all `arb_src_rdy` = 0, `arb_dst_val` = 0, `arb_frames_done` = 0. The first grant goes to port 0 one cycle after release.
- **Full round-robin:** all 4 ports stream 3-beat frames continuously → grant order 0,1,2,3,0. There is exactly 1 idle cycle between frames, and `arb_frames_done` = 5 after 5 frames.
- **Sparse request:** port 2 only, after a frame from port 3 (`rr_ptr` = 0) → port 2 is granted, `arb_dst_port_id` = 2, and `rr_ptr` becomes 3 after its last beat.
- **Stall and gap:** granted port 1 deasserts `val` for 4 cycles mid-frame while port 0 requests, and `dst_arb_rdy` toggles every cycle → no beat from port 0 is accepted until port 1's last beat. Port 1 beats arrive in order with none duplicated or dropped.
- **Single-beat frames:** port 3 sends 1-beat frames with last = 1 and padbytes = 5 → each frame appears as one beat with last = 1 and padbytes = 5, at one frame per 2 cycles.
- **Reset mid-frame:** assert `rst_n` = 0 during beat 2 of a 4-beat frame → next cycle `arb_dst_val` = 0, all `arb_src_rdy` = 0, and `arb_frames_done` = 0.

Source files
------------

// File: rtl/eth_rx_port_arbiter.sv
// rtl/eth_rx_port_arbiter.sv - frame-granular round-robin arbiter sharing one frame formatter among MAC RX ports
module eth_rx_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_ID_W       = $clog2(NUM_PORTS),
    parameter int MAC_INTERFACE_W = 64,
    parameter int MTU_SIZE_W      = 14,
    parameter int MAC_PADBYTES_W  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  src_arb_val,
    input  logic [NUM_PORTS*MAC_INTERFACE_W-1:0]  src_arb_data,
    input  logic [NUM_PORTS*MTU_SIZE_W-1:0]       src_arb_frame_size,
    input  logic [NUM_PORTS-1:0]                  src_arb_data_last,
    input  logic [NUM_PORTS*MAC_PADBYTES_W-1:0]   src_arb_data_padbytes,
    output logic [NUM_PORTS-1:0]                  arb_src_rdy,
    output logic                                  arb_dst_val,
    output logic [MAC_INTERFACE_W-1:0]            arb_dst_data,
    output logic [MTU_SIZE_W-1:0]                 arb_dst_frame_size,
    output logic                                  arb_dst_data_last,
    output logic [MAC_PADBYTES_W-1:0]             arb_dst_data_padbytes,
    input  logic                                  dst_arb_rdy,
    output logic [PORT_ID_W-1:0]                  arb_dst_port_id,
    output logic [31:0]                           arb_frames_done
);

    typedef enum logic {ARB, STREAM} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PORT_ID_W-1:0] grant_idx;
    logic [PORT_ID_W-1:0] rr_ptr;
    logic [31:0]          frames_done;

    logic [MAC_INTERFACE_W-1:0] data_a [NUM_PORTS];
    logic [MTU_SIZE_W-1:0]      size_a [NUM_PORTS];
    logic [MAC_PADBYTES_W-1:0]  pad_a  [NUM_PORTS];

    logic                 arb_found;
    logic [PORT_ID_W-1:0] arb_winner;
    logic [PORT_ID_W-1:0] cand;
    logic                 last_accept;

    // Unpack the flat per-port buses so the granted port can be selected by index.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign data_a[g] = src_arb_data[g*MAC_INTERFACE_W +: MAC_INTERFACE_W];
        assign size_a[g] = src_arb_frame_size[g*MTU_SIZE_W +: MTU_SIZE_W];
        assign pad_a[g]  = src_arb_data_padbytes[g*MAC_PADBYTES_W +: MAC_PADBYTES_W];
    end

    // Round-robin search: first requesting port at or above rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PORT_ID_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!arb_found && src_arb_val[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    assign last_accept = (state == STREAM) && src_arb_val[grant_idx] && dst_arb_rdy
                         && src_arb_data_last[grant_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: hold the grant for the whole frame, release only on an accepted last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (arb_found)   state_nxt = STREAM;
            STREAM:  if (last_accept) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Outputs: pass the granted port straight through while streaming, quiet zeros while arbitrating.
    always_comb begin
        arb_src_rdy           = '0;
        arb_dst_val           = 1'b0;
        arb_dst_data          = '0;
        arb_dst_frame_size    = '0;
        arb_dst_data_last     = 1'b0;
        arb_dst_data_padbytes = '0;
        if (state == STREAM) begin
            arb_src_rdy           = dst_arb_rdy ? (NUM_PORTS'(1) << grant_idx) : '0;
            arb_dst_val           = src_arb_val[grant_idx];
            arb_dst_data          = data_a[grant_idx];
            arb_dst_frame_size    = size_a[grant_idx];
            arb_dst_data_last     = src_arb_data_last[grant_idx];
            arb_dst_data_padbytes = pad_a[grant_idx];
        end
    end

    // Grant capture, round-robin pointer advance and completed-frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_idx   <= '0;
            rr_ptr      <= '0;
            frames_done <= '0;
        end else begin
            if (state == ARB && arb_found) begin
                grant_idx <= arb_winner;
            end
            if (last_accept) begin
                rr_ptr      <= (grant_idx == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                frames_done <= frames_done + 32'd1;
            end
        end
    end

    assign arb_dst_port_id = grant_idx;
    assign arb_frames_done = frames_done;

endmodule
